uart_rx_sequencer: RTL and testbench
====================================

Name: uart_rx_sequencer

Overview:
Controller that sequences character reception on the serial input line. It sits between the raw rx pin and the character-detection logic. It runs the per-bit sample counter (16x oversampling, one sample per clk) and the bit-index counter through start, data and stop phases. It assembles an 8-bit character LSB-first and hands it to the consumer with a valid/ack handshake, with overrun and framing-error reporting.

Parameters:
OVERSAMPLE, 16, clk cycles per serial bit; power of two, at least 4
DATA_BITS, 8, data bits per character
SAMPLE_POINT, 7, sample_cnt value at which the start bit is re-checked (mid-bit)

Ports:
clk  input  1  system clock; every rising edge is one oversample tick
reset  input  1  asynchronous, active-high reset
rx_in  input  1  raw serial line; idle high
rx_ack  input  1  consumer acknowledges rx_data; effective only while rx_valid=1
rx_data  output  DATA_BITS  last committed character
rx_valid  output  1  rx_data holds an unacknowledged character
overrun  output  1  sticky; a character was committed while rx_valid=1 and rx_ack=0
frame_err  output  1  one-cycle pulse; stop bit sampled low
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset values: rx_data=0, rx_valid=0, overrun=0, frame_err=0, busy=0. Internal: state=IDLE, sample_cnt=0, bit_cnt=0, shift register=0, synchronizer flops=1.
- rx_in passes through a 2-flop synchronizer (rx_s). All decisions use rx_s. There are 2 clks of input latency.
- Counter widths: sample_cnt is $clog2(OVERSAMPLE) bits and bit_cnt is $clog2(DATA_BITS) bits. Both reset to 0 on every state entry.
- IDLE:
  - If rx_s=0, go to START with sample_cnt=0.
- START:
  - sample_cnt increments each clk.
  - At sample_cnt==SAMPLE_POINT: if rx_s=0, go to DATA (sample_cnt=0, bit_cnt=0). If rx_s=1, this is a glitch/false start: go to IDLE with no output change.
- DATA:
  - sample_cnt increments each clk.
  - At sample_cnt==OVERSAMPLE-1: shift rx_s in at the MSB, shifting right, so bit 0 ends at LSB. Then sample_cnt=0 and bit_cnt++.
  - The sample taken when bit_cnt==DATA_BITS-1 moves to STOP.
- STOP:
  - At sample_cnt==OVERSAMPLE-1:
    - If rx_s=1: commit (rx_data <= shift reg, rx_valid <= 1), go to IDLE.
    - If rx_s=0: frame_err pulses 1 clk, data is discarded, go to BREAK.
- BREAK:
  - Wait for rx_s=1, then go to IDLE. A line held low never retriggers START.
- Timing with defaults, where E0 is the edge at which IDLE sees rx_s=0:
  - Start check at E8.
  - Data bit n sampled at E(24+16n).
  - Stop sampled at E152.
  - rx_valid or frame_err is visible after E152.
- Handshake:
  - rx_valid clears on the edge where rx_valid=1 and rx_ack=1.
  - rx_ack while rx_valid=0 is ignored.
  - overrun clears on any accepted ack.
- Simultaneous commit and accepted ack on one edge: new data loads, rx_valid stays 1, overrun is not set and not cleared.
- Commit while rx_valid=1 and rx_ack=0: new data overwrites rx_data, overrun <= 1.
- Reset asserted mid-frame: all state and outputs return to reset values immediately, asynchronously. After reset releases, reception restarts only on a fresh falling edge.

Decomposition:
- Package uart_rx_pkg holds:
  - the state enum typedef (IDLE, START, DATA, STOP, BREAK), 3-bit encoding;
  - default constants OVERSAMPLE_DEF=16, DATA_BITS_DEF=8, SAMPLE_POINT_DEF=7.
- One sub-module: sync_2ff, a two-flop synchronizer with asynchronous active-high reset to 1.
- The counters, FSM and output registers stay in uart_rx_sequencer.

Test Plan:
1. Send 0xA5 (start, bits LSB-first 1,0,1,0,0,1,0,1, stop) at 16 clk/bit, rx_ack=0. Expect rx_valid=1 and rx_data=8'hA5 at 152 clks after IDLE sees rx_s=0; frame_err never pulses; busy falls the same cycle.
2. Pulse rx_in low for 4 clks only. Expect START abort at the mid-bit check, return to IDLE, rx_valid=0, busy high for 8 clks.
3. Send 0x3C with the stop bit low, then hold rx_in low for 40 clks, then high. Expect a 1-clk frame_err pulse, rx_valid stays 0, and no START re-entry until the line goes high.
4. Send 0x11 then 0x22 with no ack. Expect rx_data=8'h22, rx_valid=1, overrun=1. Then pulse rx_ack for 1 clk: expect rx_valid=0, overrun=0.
5. Send 0x55; hold rx_valid from a prior 0x11. Assert rx_ack exactly on the commit edge of 0x55. Expect rx_data=8'h55, rx_valid=1, overrun=0.
6. Assert reset at clk 70 of an in-flight 0xFF frame. Expect all outputs 0 immediately; a following clean 0x81 is received correctly.

Source files
------------

// File: rtl/uart_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_pkg
// Description : Shared state encoding and default sizing for the UART receiver.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_rx_pkg;

    localparam int OVERSAMPLE_DEF   = 16;
    localparam int DATA_BITS_DEF    = 8;
    localparam int SAMPLE_POINT_DEF = 7;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rxState_e;

endpackage
`default_nettype wire

// File: rtl/uart_rx_sequencer_sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Two-flop synchronizer; resets to the idle-high line level.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_rx_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_sequencer
// Description : 16x-oversampled UART receive sequencer with valid/ack handoff.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_sequencer
    import uart_rx_pkg::*;
#(
    parameter int OVERSAMPLE   = OVERSAMPLE_DEF,
    parameter int DATA_BITS    = DATA_BITS_DEF,
    parameter int SAMPLE_POINT = SAMPLE_POINT_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_in,
    input  logic                 rx_ack,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 overrun,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int c_SC_W = $clog2(OVERSAMPLE);
    localparam int c_BC_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [c_SC_W-1:0] c_SAMPLE_MID  = c_SC_W'(SAMPLE_POINT);
    localparam logic [c_SC_W-1:0] c_SAMPLE_LAST = c_SC_W'(OVERSAMPLE - 1);
    localparam logic [c_BC_W-1:0] c_BIT_LAST    = c_BC_W'(DATA_BITS - 1);

    rxState_e             r_state;
    logic [c_SC_W-1:0]    r_sampleCnt;
    logic [c_BC_W-1:0]    r_bitCnt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_rxData;
    logic                 r_rxValid;
    logic                 r_overrun;
    logic                 r_frameErr;
    logic                 w_rxS;
    logic                 w_ackTaken;

    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (rx_in),
        .o_q   (w_rxS)
    );

    assign w_ackTaken = r_rxValid & rx_ack;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_sampleCnt <= '0;
            r_bitCnt    <= '0;
            r_shift     <= '0;
            r_rxData    <= '0;
            r_rxValid   <= 1'b0;
            r_overrun   <= 1'b0;
            r_frameErr  <= 1'b0;
        end else begin
            r_frameErr <= 1'b0;
            // A commit in STOP below overrides these when both happen together.
            if (w_ackTaken) begin
                r_rxValid <= 1'b0;
                r_overrun <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (!w_rxS) begin
                        r_state     <= START;
                        r_sampleCnt <= '0;
                        r_bitCnt    <= '0;
                    end
                end
                START: begin
                    if (r_sampleCnt == c_SAMPLE_MID) begin
                        r_state     <= w_rxS ? IDLE : DATA;
                        r_sampleCnt <= '0;
                        r_bitCnt    <= '0;
                    end else begin
                        r_sampleCnt <= r_sampleCnt + c_SC_W'(1);
                    end
                end
                DATA: begin
                    if (r_sampleCnt == c_SAMPLE_LAST) begin
                        r_shift     <= {w_rxS, r_shift[DATA_BITS-1:1]};
                        r_sampleCnt <= '0;
                        if (r_bitCnt == c_BIT_LAST) begin
                            r_state  <= STOP;
                            r_bitCnt <= '0;
                        end else begin
                            r_bitCnt <= r_bitCnt + c_BC_W'(1);
                        end
                    end else begin
                        r_sampleCnt <= r_sampleCnt + c_SC_W'(1);
                    end
                end
                STOP: begin
                    if (r_sampleCnt == c_SAMPLE_LAST) begin
                        r_sampleCnt <= '0;
                        if (w_rxS) begin
                            r_rxData  <= r_shift;
                            r_rxValid <= 1'b1;
                            // Overrun only when the old character is lost unacknowledged.
                            r_overrun <= r_overrun | (r_rxValid & ~rx_ack);
                            r_state   <= IDLE;
                        end else begin
                            r_frameErr <= 1'b1;
                            r_state    <= BREAK;
                        end
                    end else begin
                        r_sampleCnt <= r_sampleCnt + c_SC_W'(1);
                    end
                end
                BREAK: begin
                    r_sampleCnt <= '0;
                    if (w_rxS) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_sampleCnt <= '0;
                    r_bitCnt    <= '0;
                end
            endcase
        end
    end

    assign rx_data   = r_rxData;
    assign rx_valid  = r_rxValid;
    assign overrun   = r_overrun;
    assign frame_err = r_frameErr;
    assign busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_sequencer
// Description : Directed, table-driven bench for uart_rx_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_sequencer;

    localparam int OS        = 16;
    localparam int DONE_EDGE = 155; // 3 edges to reach E0, then E152

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_in;
    logic       rx_ack;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       overrun;
    logic       frame_err;
    logic       busy;

    int tests = 0;
    int fails = 0;
    int doneEdge;
    int riseEdge;
    int feEdge;
    int feCount;

    typedef struct {
        logic [7:0] data;
        bit         ackBefore;
        bit         ackCommit;
        logic [7:0] expData;
        bit         expValid;
        bit         expOvr;
        int         expRise;
    } vec_t;

    vec_t vecs[6];

    uart_rx_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .rx_in     (rx_in),
        .rx_ack    (rx_ack),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .overrun   (overrun),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one frame, one bit per OS edges; optionally acks on the commit edge
    // or asserts reset partway through.
    task automatic sendFrame(input logic [7:0] data, input bit stopBit,
                             input bit ackCommit, input int resetAt);
        logic [9:0] bits;
        logic       prevBusy;
        logic       prevValid;
        bits      = {stopBit, data, 1'b0};
        doneEdge  = -1;
        riseEdge  = -1;
        feEdge    = -1;
        feCount   = 0;
        prevBusy  = busy;
        prevValid = rx_valid;
        for (int c = 0; c < 10 * OS; c++) begin
            rx_in  = bits[c / OS];
            rx_ack = ackCommit && (c == DONE_EDGE - 1);
            if (c == resetAt) begin
                reset = 1'b1;
                #1;
                check("async_rst_data",  32'(rx_data),   32'h0);
                check("async_rst_valid", 32'(rx_valid),  32'h0);
                check("async_rst_ovr",   32'(overrun),   32'h0);
                check("async_rst_fe",    32'(frame_err), 32'h0);
                check("async_rst_busy",  32'(busy),      32'h0);
                return;
            end
            tick();
            if (frame_err) begin
                feCount++;
                if (feEdge < 0) feEdge = c + 1;
            end
            if (prevBusy && !busy && doneEdge < 0) doneEdge = c + 1;
            if (!prevValid && rx_valid && riseEdge < 0) riseEdge = c + 1;
            prevBusy  = busy;
            prevValid = rx_valid;
        end
        rx_ack = 1'b0;
    endtask

    initial begin
        int busyCnt;
        int feCnt;

        vecs[0] = '{8'hA5, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, DONE_EDGE};
        vecs[1] = '{8'h11, 1'b1, 1'b0, 8'h11, 1'b1, 1'b0, DONE_EDGE};
        vecs[2] = '{8'h22, 1'b0, 1'b0, 8'h22, 1'b1, 1'b1, 0};
        vecs[3] = '{8'h44, 1'b0, 1'b1, 8'h44, 1'b1, 1'b1, 0};
        vecs[4] = '{8'h11, 1'b1, 1'b0, 8'h11, 1'b1, 1'b0, DONE_EDGE};
        vecs[5] = '{8'h55, 1'b0, 1'b1, 8'h55, 1'b1, 1'b0, 0};

        reset  = 1'b1;
        rx_in  = 1'b1;
        rx_ack = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("rst_data",  32'(rx_data),   32'h0);
        check("rst_valid", 32'(rx_valid),  32'h0);
        check("rst_ovr",   32'(overrun),   32'h0);
        check("rst_fe",    32'(frame_err), 32'h0);
        check("rst_busy",  32'(busy),      32'h0);

        // Short low glitch: START aborts at the mid-bit check.
        busyCnt = 0;
        feCnt   = 0;
        for (int c = 0; c < 24; c++) begin
            rx_in = (c < 4) ? 1'b0 : 1'b1;
            tick();
            if (busy) busyCnt++;
            if (frame_err) feCnt++;
        end
        check("glitch_busy_cycles", 32'(busyCnt),  32'd8);
        check("glitch_valid",       32'(rx_valid), 32'h0);
        check("glitch_fe",          32'(feCnt),    32'h0);

        // Framing error followed by a held-low line.
        sendFrame(8'h3C, 1'b0, 1'b0, -1);
        check("fe_count", 32'(feCount),  32'd1);
        check("fe_edge",  32'(feEdge),   32'(DONE_EDGE));
        check("fe_valid", 32'(rx_valid), 32'h0);
        busyCnt = 0;
        feCnt   = 0;
        for (int c = 0; c < 40; c++) begin
            rx_in = 1'b0;
            tick();
            if (busy) busyCnt++;
            if (frame_err) feCnt++;
        end
        check("break_busy_held", 32'(busyCnt), 32'd40);
        check("break_no_fe",     32'(feCnt),   32'h0);
        rx_in = 1'b1;
        repeat (5) tick();
        check("break_exit_busy",  32'(busy),     32'h0);
        check("break_exit_valid", 32'(rx_valid), 32'h0);

        foreach (vecs[i]) begin
            if (vecs[i].ackBefore) begin
                rx_ack = 1'b1;
                tick();
                rx_ack = 1'b0;
                check("ack_clears_valid", 32'(rx_valid), 32'h0);
                check("ack_clears_ovr",   32'(overrun),  32'h0);
            end
            sendFrame(vecs[i].data, 1'b1, vecs[i].ackCommit, -1);
            repeat (2) tick();
            check("vec_data",  32'(rx_data),  32'(vecs[i].expData));
            check("vec_valid", 32'(rx_valid), 32'(vecs[i].expValid));
            check("vec_ovr",   32'(overrun),  32'(vecs[i].expOvr));
            check("vec_done",  32'(doneEdge), 32'(DONE_EDGE));
            check("vec_no_fe", 32'(feCount),  32'h0);
            if (vecs[i].expRise > 0)
                check("vec_valid_rise", 32'(riseEdge), 32'(vecs[i].expRise));
        end

        // Reset mid-frame, then a clean frame.
        sendFrame(8'hFF, 1'b1, 1'b0, 70);
        rx_in = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        busyCnt = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (busy) busyCnt++;
        end
        check("post_rst_idle", 32'(busyCnt), 32'h0);
        sendFrame(8'h81, 1'b1, 1'b0, -1);
        repeat (2) tick();
        check("post_rst_data",  32'(rx_data),  32'h81);
        check("post_rst_valid", 32'(rx_valid), 32'h1);
        check("post_rst_ovr",   32'(overrun),  32'h0);
        check("post_rst_rise",  32'(riseEdge), 32'(DONE_EDGE));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
